// File: rtl/pause_frame_req_gen.sv
// PAUSE frame request generator: turns the per-cycle XOFF/XON command stream into
// valid/ready PAUSE requests, refreshing XOFF before the partner's quanta runs out.
module pause_frame_req_gen #(
    parameter int                   QUANTA_W       = 16,
    parameter logic [QUANTA_W-1:0]  XOFF_QUANTA    = 16'hFFFF,
    parameter int                   REFRESH_W      = 24,
    parameter logic [REFRESH_W-1:0] REFRESH_PERIOD = 24'd1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          in_data,
    output logic                pause_valid,
    input  logic                pause_ready,
    output logic [QUANTA_W-1:0] pause_quanta,
    output logic                tx_paused,
    output logic [15:0]         xoff_sent,
    output logic [15:0]         xon_sent
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_XOFF = 2'd1,
        PAUSED    = 2'd2,
        SEND_XON  = 2'd3
    } state_t;

    localparam logic [REFRESH_W-1:0] RELOAD = REFRESH_PERIOD - 1'b1;

    state_t               state_reg, state_next;
    logic                 want_reg, want_next;
    logic [REFRESH_W-1:0] refresh_reg, refresh_next;
    logic                 valid_reg, valid_next;
    logic [QUANTA_W-1:0]  quanta_reg, quanta_next;
    logic                 paused_reg, paused_next;
    logic [15:0]          xoff_cnt_reg, xoff_cnt_next;
    logic [15:0]          xon_cnt_reg, xon_cnt_next;
    logic                 accept;

    // valid_reg is high exactly while in a SEND_* state, so this is the handshake.
    assign accept = valid_reg & pause_ready;

    // XOFF wins when both request bits are set; 00 holds the desired state.
    always_comb begin
        want_next = want_reg;
        if (in_data[1])
            want_next = 1'b1;
        else if (in_data[0])
            want_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (want_reg) state_next = SEND_XOFF;
            SEND_XOFF: if (accept) state_next = PAUSED;
            PAUSED: begin
                if (!want_reg)
                    state_next = SEND_XON;
                else if (refresh_reg == '0)
                    state_next = SEND_XOFF;
            end
            SEND_XON:  if (accept) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_comb begin
        valid_next    = (state_next == SEND_XOFF) || (state_next == SEND_XON);
        quanta_next   = (state_next == SEND_XOFF) ? XOFF_QUANTA : '0;
        paused_next   = paused_reg;
        xoff_cnt_next = xoff_cnt_reg;
        xon_cnt_next  = xon_cnt_reg;
        refresh_next  = refresh_reg;
        if (state_reg == SEND_XOFF && accept) begin
            paused_next   = 1'b1;
            xoff_cnt_next = xoff_cnt_reg + 16'd1;
            refresh_next  = RELOAD;
        end else if (state_reg == SEND_XON && accept) begin
            paused_next  = 1'b0;
            xon_cnt_next = xon_cnt_reg + 16'd1;
        end else if (state_reg == PAUSED && refresh_reg != '0) begin
            refresh_next = refresh_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            want_reg     <= 1'b0;
            refresh_reg  <= '0;
            valid_reg    <= 1'b0;
            quanta_reg   <= '0;
            paused_reg   <= 1'b0;
            xoff_cnt_reg <= '0;
            xon_cnt_reg  <= '0;
        end else begin
            want_reg     <= want_next;
            refresh_reg  <= refresh_next;
            valid_reg    <= valid_next;
            quanta_reg   <= quanta_next;
            paused_reg   <= paused_next;
            xoff_cnt_reg <= xoff_cnt_next;
            xon_cnt_reg  <= xon_cnt_next;
        end
    end

    assign pause_valid  = valid_reg;
    assign pause_quanta = quanta_reg;
    assign tx_paused    = paused_reg;
    assign xoff_sent    = xoff_cnt_reg;
    assign xon_sent     = xon_cnt_reg;

endmodule

// File: tb/tb_pause_frame_req_gen.sv
// Directed bench for pause_frame_req_gen: per-cycle vector table with hand-computed
// outputs, then a handshake-timed refresh/XON sequence.
module tb_pause_frame_req_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_data;
    logic        pause_valid;
    logic        pause_ready;
    logic [15:0] pause_quanta;
    logic        tx_paused;
    logic [15:0] xoff_sent;
    logic [15:0] xon_sent;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pause_frame_req_gen #(
        .QUANTA_W(16),
        .XOFF_QUANTA(16'hFFFF),
        .REFRESH_W(24),
        .REFRESH_PERIOD(24'd8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .pause_valid(pause_valid),
        .pause_ready(pause_ready),
        .pause_quanta(pause_quanta),
        .tx_paused(tx_paused),
        .xoff_sent(xoff_sent),
        .xon_sent(xon_sent)
    );

    // One row: inputs presented in a cycle, outputs expected just after that cycle's edge.
    typedef struct {
        logic        rst;
        logic [1:0]  din;
        logic        rdy;
        logic        valid;
        logic [15:0] quanta;
        logic        paused;
        logic [15:0] xoff;
        logic [15:0] xon;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] d, input logic rd, input logic v,
                       input logic [15:0] q, input logic tp, input logic [15:0] xo,
                       input logic [15:0] xn);
        vec_t t;
        t.rst = r; t.din = d; t.rdy = rd; t.valid = v;
        t.quanta = q; t.paused = tp; t.xoff = xo; t.xon = xn;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_table();
        add(1, 2'b00, 0, 0, 16'h0, 0, 0, 0);
        // XON while idle is absorbed
        for (int i = 0; i < 10; i++) add(0, 2'b01, 1, 0, 16'h0, 0, 0, 0);
        // XOFF: valid two edges later, accepted immediately
        add(0, 2'b10, 1, 0, 16'h0, 0, 0, 0);
        add(0, 2'b00, 1, 1, 16'hFFFF, 0, 0, 0);
        add(0, 2'b00, 1, 0, 16'h0, 1, 1, 0);
        // two refreshes, 9 cycles apart
        for (int k = 1; k <= 2; k++) begin
            for (int i = 0; i < 7; i++) add(0, 2'b00, 1, 0, 16'h0, 1, 16'(k), 0);
            add(0, 2'b00, 1, 1, 16'hFFFF, 1, 16'(k), 0);
            add(0, 2'b00, 1, 0, 16'h0, 1, 16'(k + 1), 0);
        end
        // refresh stalled by ready=0 while XON arrives; request must not change
        for (int i = 0; i < 7; i++) add(0, 2'b00, 0, 0, 16'h0, 1, 3, 0);
        add(0, 2'b00, 0, 1, 16'hFFFF, 1, 3, 0);
        for (int i = 0; i < 5; i++) add(0, 2'b01, 0, 1, 16'hFFFF, 1, 3, 0);
        add(0, 2'b00, 1, 0, 16'h0, 1, 4, 0);
        add(0, 2'b00, 1, 1, 16'h0, 1, 4, 0);
        add(0, 2'b00, 1, 0, 16'h0, 0, 4, 1);
        add(0, 2'b00, 1, 0, 16'h0, 0, 4, 1);
        // 11 behaves as XOFF; XON coincides with refresh expiry
        add(0, 2'b11, 1, 0, 16'h0, 0, 4, 1);
        add(0, 2'b00, 1, 1, 16'hFFFF, 0, 4, 1);
        add(0, 2'b00, 1, 0, 16'h0, 1, 5, 1);
        for (int i = 0; i < 6; i++) add(0, 2'b00, 1, 0, 16'h0, 1, 5, 1);
        add(0, 2'b01, 1, 0, 16'h0, 1, 5, 1);
        add(0, 2'b00, 1, 1, 16'h0, 1, 5, 1);
        add(0, 2'b00, 1, 0, 16'h0, 0, 5, 2);
        add(0, 2'b00, 1, 0, 16'h0, 0, 5, 2);
        // reset during a pending XOFF request
        add(0, 2'b10, 0, 0, 16'h0, 0, 5, 2);
        add(0, 2'b00, 0, 1, 16'hFFFF, 0, 5, 2);
        add(0, 2'b00, 0, 1, 16'hFFFF, 0, 5, 2);
        add(1, 2'b00, 0, 0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 2'b00, 1, 0, 16'h0, 0, 0, 0);
    endtask

    // Waits (bounded) until a request is visible before the next edge; returns cycles used.
    task automatic wait_valid(input int budget, output int used, output bit ok);
        used = 0;
        ok = 1'b0;
        while (used < budget) begin
            @(negedge clk);
            used++;
            if (pause_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  used;
        int  gap;
        bit  ok;
        reset = 1'b1;
        in_data = 2'b00;
        pause_ready = 1'b0;

        fill_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            in_data = vecs[i].din;
            pause_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid", i), 32'(pause_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d quanta", i), 32'(pause_quanta), 32'(vecs[i].quanta));
            check($sformatf("v%0d tx_paused", i), 32'(tx_paused), 32'(vecs[i].paused));
            check($sformatf("v%0d xoff_sent", i), 32'(xoff_sent), 32'(vecs[i].xoff));
            check($sformatf("v%0d xon_sent", i), 32'(xon_sent), 32'(vecs[i].xon));
            $display("vec %0d: rst=%0b in=%02b rdy=%0b -> valid=%0b q=%04h paused=%0b xoff=%0d xon=%0d",
                     i, vecs[i].rst, vecs[i].din, vecs[i].rdy, pause_valid, pause_quanta,
                     tx_paused, xoff_sent, xon_sent);
        end

        // Handshake-timed sequence: refresh spacing measured between acceptances.
        @(negedge clk);
        pause_ready = 1'b1;
        in_data = 2'b10;
        @(negedge clk);
        in_data = 2'b00;
        wait_valid(20, used, ok);
        check("seq first xoff seen", 32'(ok), 32'd1);
        check("seq first xoff quanta", 32'(pause_quanta), 32'hFFFF);
        wait_valid(20, gap, ok);
        check("seq refresh seen", 32'(ok), 32'd1);
        check("seq refresh gap", 32'(gap), 32'd9);
        $display("seq: refresh gap=%0d cycles, xoff_sent=%0d", gap, xoff_sent);
        in_data = 2'b01;
        @(negedge clk);
        in_data = 2'b00;
        wait_valid(20, used, ok);
        check("seq xon seen", 32'(ok), 32'd1);
        check("seq xon quanta", 32'(pause_quanta), 32'h0);
        @(negedge clk);
        check("seq tx_paused after xon", 32'(tx_paused), 32'd0);
        check("seq xoff_sent", 32'(xoff_sent), 32'd2);
        check("seq xon_sent", 32'(xon_sent), 32'd1);
        $display("seq: xon accepted, xoff_sent=%0d xon_sent=%0d", xoff_sent, xon_sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
